// File: rtl/sub_rr_arb_if.sv
// Stream bundle between the two producers, the arbiter and the shared sub2 datapath.
interface sub_rr_arb_if #(
  parameter int unsigned DW = 8
);
  logic          i_sig_valid0;
  logic [DW-1:0] i_sig_data0;
  logic          o_sig_ready0;
  logic          i_sig_valid1;
  logic [DW-1:0] i_sig_data1;
  logic          o_sig_ready1;
  logic          o_sig_valid;
  logic [DW-1:0] o_sig_data;
  logic          o_sig_src;
  logic          i_sig_ready;

  // Arbiter side
  modport slave (
    input  i_sig_valid0, i_sig_data0, i_sig_valid1, i_sig_data1, i_sig_ready,
    output o_sig_ready0, o_sig_ready1, o_sig_valid, o_sig_data, o_sig_src
  );

  // Producer/consumer side
  modport master (
    output i_sig_valid0, i_sig_data0, i_sig_valid1, i_sig_data1, i_sig_ready,
    input  o_sig_ready0, o_sig_ready1, o_sig_valid, o_sig_data, o_sig_src
  );
endinterface

// File: rtl/sub_rr_arb.sv
// Two-requester round-robin arbiter with per-requester 2-entry FIFOs,
// burst-limited grant FSM and a single registered, source-tagged output stage.
module sub_rr_arb #(
  parameter int unsigned DW        = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  sub_rr_arb_if.slave     bus,
  input  logic            i_cfg_en,
  output logic            o_busy
);

  localparam int unsigned BCW = 4;
  localparam logic [BCW-1:0] BURST_LIM = BCW'(MAX_BURST);
  localparam logic [BCW-1:0] BURST_SAT = {BCW{1'b1}};

  typedef enum logic [1:0] {ST_IDLE, ST_G0, ST_G1} state_t;

  // FIFO state, indexed by requester
  logic [DW-1:0] mem_q [2][2];
  logic          wp_q  [2];
  logic          rp_q  [2];
  logic [1:0]    cnt_q [2];
  logic [1:0]    cnt_d [2];

  // Output stage and grant FSM registers
  logic          valid_q;
  logic          src_q;
  logic [DW-1:0] data_q;
  logic          busy_q;
  state_t        state_q;
  logic [BCW-1:0] burst_q;
  logic          last_q;

  logic [DW-1:0] in_data [2];
  logic [1:0]    in_valid;
  logic [1:0]    ne;
  logic [1:0]    full;
  logic [1:0]    wr;
  logic [1:0]    pop;
  logic          sel;
  logic          owner;
  logic          load;
  logic          valid_d;
  logic [DW-1:0] head_sel;

  // FIFO status, write enables and next occupancy
  always_comb begin
    in_valid   = {bus.i_sig_valid1, bus.i_sig_valid0};
    in_data[0] = bus.i_sig_data0;
    in_data[1] = bus.i_sig_data1;
    for (int i = 0; i < 2; i++) begin
      ne[i]    = (cnt_q[i] != 2'd0);
      full[i]  = (cnt_q[i] == 2'd2);
      wr[i]    = in_valid[i] & ~full[i];
      cnt_d[i] = cnt_q[i] + {1'b0, wr[i]} - {1'b0, pop[i]};
    end
  end

  // Grant selection: keep the owner until its burst limit, switch early if it runs dry
  always_comb begin
    sel   = 1'b0;
    owner = (state_q == ST_G1);
    case (state_q)
      ST_G0:   sel = (ne[0] && ((burst_q < BURST_LIM) || !ne[1])) ? 1'b0 : 1'b1;
      ST_G1:   sel = (ne[1] && ((burst_q < BURST_LIM) || !ne[0])) ? 1'b1 : 1'b0;
      default: sel = (ne[0] && ne[1]) ? ~last_q : ~ne[0];
    endcase
  end

  // Output-stage load and FIFO pop
  always_comb begin
    load     = i_cfg_en & (~valid_q | bus.i_sig_ready) & (|ne);
    pop      = 2'b00;
    pop[sel] = load;
    head_sel = mem_q[sel][rp_q[sel]];
    valid_d  = load | (valid_q & ~bus.i_sig_ready);
  end

  // Per-requester 2-entry FIFOs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i][0] <= '0;
        mem_q[i][1] <= '0;
        wp_q[i]     <= 1'b0;
        rp_q[i]     <= 1'b0;
        cnt_q[i]    <= 2'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (wr[i]) begin
          mem_q[i][wp_q[i]] <= in_data[i];
          wp_q[i]           <= ~wp_q[i];
        end
        if (pop[i]) begin
          rp_q[i] <= ~rp_q[i];
        end
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Registered output stage: load from the granted FIFO, hold while stalled
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      src_q   <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      if (load) begin
        data_q <= head_sel;
        src_q  <= sel;
      end
      valid_q <= valid_d;
      busy_q  <= (cnt_d[0] != 2'd0) | (cnt_d[1] != 2'd0) | valid_d;
    end
  end

  // Grant FSM: owner state, burst count and last-granted index
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      burst_q <= '0;
      last_q  <= 1'b1;
    end else if (load) begin
      if (state_q == ST_IDLE) begin
        state_q <= sel ? ST_G1 : ST_G0;
        burst_q <= BCW'(1);
      end else if (sel != owner) begin
        state_q <= sel ? ST_G1 : ST_G0;
        burst_q <= BCW'(1);
        last_q  <= owner;
      end else if (burst_q != BURST_SAT) begin
        burst_q <= burst_q + BCW'(1);
      end
    end else if ((ne == 2'b00) && (state_q != ST_IDLE)) begin
      state_q <= ST_IDLE;
      last_q  <= owner;
    end
  end

  // Readiness comes only from FIFO occupancy; forced low during reset
  assign bus.o_sig_ready0 = ~full[0] & ~i_rst;
  assign bus.o_sig_ready1 = ~full[1] & ~i_rst;
  assign bus.o_sig_valid  = valid_q;
  assign bus.o_sig_data   = data_q;
  assign bus.o_sig_src    = src_q;
  assign o_busy           = busy_q;

endmodule

// File: tb/tb_sub_rr_arb.sv
// Directed testbench for sub_rr_arb.
module tb_sub_rr_arb;
  localparam int unsigned DW = 8;
  localparam int unsigned MB = 4;

  logic i_clk;
  logic i_rst;
  logic cfg_en;
  logic busy;

  sub_rr_arb_if #(.DW(DW)) bus ();

  sub_rr_arb #(.DW(DW), .MAX_BURST(MB)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .bus      (bus),
    .i_cfg_en (cfg_en),
    .o_busy   (busy)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [7:0] d0 [$];
  logic [7:0] d1 [$];
  logic [7:0] cap_data [$];
  logic       cap_src  [$];
  int         cap_cyc  [$];

  // Present the head of each producer queue
  task automatic drive_inputs();
    bus.i_sig_valid0 = (d0.size() > 0);
    bus.i_sig_data0  = (d0.size() > 0) ? d0[0] : 8'h00;
    bus.i_sig_valid1 = (d1.size() > 0);
    bus.i_sig_data1  = (d1.size() > 0) ? d1[0] : 8'h00;
  endtask

  task automatic clear_all();
    d0.delete(); d1.delete();
    cap_data.delete(); cap_src.delete(); cap_cyc.delete();
  endtask

  // One clock: note transfers happening at this edge, then sample #1 after it
  task automatic step();
    logic a0, a1;
    drive_inputs();
    a0 = bus.i_sig_valid0 & bus.o_sig_ready0;
    a1 = bus.i_sig_valid1 & bus.o_sig_ready1;
    if (bus.o_sig_valid && bus.i_sig_ready) begin
      cap_data.push_back(bus.o_sig_data);
      cap_src.push_back(bus.o_sig_src);
      cap_cyc.push_back(cyc);
    end
    @(posedge i_clk); #1;
    cyc++;
    if (a0) void'(d0.pop_front());
    if (a1) void'(d1.pop_front());
  endtask

  task automatic do_reset();
    clear_all();
    i_rst = 1'b1;
    cfg_en = 1'b1;
    bus.i_sig_ready = 1'b1;
    drive_inputs();
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_all();
    i_rst = 1'b1;
    cfg_en = 1'b1;
    bus.i_sig_ready = 1'b1;
    drive_inputs();
    @(posedge i_clk); #1;
    n_chk++; if (bus.o_sig_ready0 !== 1'b0) begin n_fail++; $display("FAIL reset_rdy0_in_rst: got %b want 0", bus.o_sig_ready0); end
    n_chk++; if (bus.o_sig_ready1 !== 1'b0) begin n_fail++; $display("FAIL reset_rdy1_in_rst: got %b want 0", bus.o_sig_ready1); end
    i_rst = 1'b0;
    #1;
    n_chk++; if (bus.o_sig_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.o_sig_valid); end
    n_chk++; if (bus.o_sig_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", bus.o_sig_data); end
    n_chk++; if (bus.o_sig_src !== 1'b0) begin n_fail++; $display("FAIL reset_src: got %b want 0", bus.o_sig_src); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_chk++; if (bus.o_sig_ready0 !== 1'b1) begin n_fail++; $display("FAIL reset_rdy0: got %b want 1", bus.o_sig_ready0); end
    n_chk++; if (bus.o_sig_ready1 !== 1'b1) begin n_fail++; $display("FAIL reset_rdy1: got %b want 1", bus.o_sig_ready1); end
  endtask

  task automatic test_single();
    do_reset();
    d0 = '{8'h11, 8'h22, 8'h33};
    step();
    n_chk++; if (bus.o_sig_valid !== 1'b0) begin n_fail++; $display("FAIL single_latency: got valid %b want 0", bus.o_sig_valid); end
    step();
    n_chk++; if ({bus.o_sig_valid, bus.o_sig_src, bus.o_sig_data} !== {1'b1, 1'b0, 8'h11}) begin n_fail++; $display("FAIL single_beat0: got v%b s%b %h want v1 s0 11", bus.o_sig_valid, bus.o_sig_src, bus.o_sig_data); end
    step();
    n_chk++; if ({bus.o_sig_valid, bus.o_sig_src, bus.o_sig_data} !== {1'b1, 1'b0, 8'h22}) begin n_fail++; $display("FAIL single_beat1: got v%b s%b %h want v1 s0 22", bus.o_sig_valid, bus.o_sig_src, bus.o_sig_data); end
    step();
    n_chk++; if ({bus.o_sig_valid, bus.o_sig_src, bus.o_sig_data} !== {1'b1, 1'b0, 8'h33}) begin n_fail++; $display("FAIL single_beat2: got v%b s%b %h want v1 s0 33", bus.o_sig_valid, bus.o_sig_src, bus.o_sig_data); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_last: got %b want 1", busy); end
    step();
    n_chk++; if (bus.o_sig_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained: got valid %b want 0", bus.o_sig_valid); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_fall: got %b want 0", busy); end
  endtask

  task automatic test_tie_burst();
    logic       es;
    logic [7:0] ed;
    int         idx;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      d0.push_back(8'(i));
      d1.push_back(8'(8'h80 + i));
    end
    repeat (20) step();
    n_chk++; if (cap_src.size() < 16) begin n_fail++; $display("FAIL tie_count: got %0d beats want >=16", cap_src.size()); end
    for (int k = 0; k < 16; k++) begin
      es  = 1'((k / 4) % 2);
      idx = (k / 8) * 4 + (k % 4);
      ed  = es ? 8'(8'h80 + idx) : 8'(idx);
      n_chk++;
      if (k >= cap_src.size() || cap_src[k] !== es || cap_data[k] !== ed) begin
        n_fail++;
        $display("FAIL tie_beat%0d: got s%b %h want s%b %h", k,
                 (k < cap_src.size()) ? cap_src[k] : 1'bx,
                 (k < cap_data.size()) ? cap_data[k] : 8'hxx, es, ed);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] ed [8];
    logic       es [8];
    ed = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h80, 8'h81, 8'h82, 8'h83};
    es = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    bus.i_sig_ready = 1'b0;
    d0 = '{8'h00, 8'h01, 8'h02, 8'h03};
    d1 = '{8'h80, 8'h81, 8'h82, 8'h83};
    step();
    step();
    for (int s = 0; s < 5; s++) begin
      n_chk++;
      if ({bus.o_sig_valid, bus.o_sig_src, bus.o_sig_data} !== {1'b1, 1'b0, 8'h00}) begin
        n_fail++;
        $display("FAIL bp_stable%0d: got v%b s%b %h want v1 s0 00", s, bus.o_sig_valid, bus.o_sig_src, bus.o_sig_data);
      end
      if (s < 4) step();
    end
    n_chk++; if (bus.o_sig_ready0 !== 1'b0) begin n_fail++; $display("FAIL bp_rdy0_low: got %b want 0", bus.o_sig_ready0); end
    n_chk++; if (bus.o_sig_ready1 !== 1'b0) begin n_fail++; $display("FAIL bp_rdy1_low: got %b want 0", bus.o_sig_ready1); end
    bus.i_sig_ready = 1'b1;
    repeat (14) step();
    n_chk++; if (cap_data.size() != 8) begin n_fail++; $display("FAIL bp_count: got %0d beats want 8", cap_data.size()); end
    for (int k = 0; k < 8; k++) begin
      n_chk++;
      if (k >= cap_data.size() || cap_src[k] !== es[k] || cap_data[k] !== ed[k]) begin
        n_fail++;
        $display("FAIL bp_beat%0d: got s%b %h want s%b %h", k,
                 (k < cap_src.size()) ? cap_src[k] : 1'bx,
                 (k < cap_data.size()) ? cap_data[k] : 8'hxx, es[k], ed[k]);
      end
    end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got busy %b want 0", busy); end
  endtask

  task automatic test_early_switch();
    logic [7:0] ed [7];
    logic       es [7];
    ed = '{8'h10, 8'h11, 8'h90, 8'h91, 8'h92, 8'h93, 8'h94};
    es = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    d0 = '{8'h10, 8'h11};
    d1 = '{8'h90, 8'h91, 8'h92, 8'h93, 8'h94};
    repeat (14) step();
    n_chk++; if (cap_data.size() != 7) begin n_fail++; $display("FAIL early_count: got %0d beats want 7", cap_data.size()); end
    for (int k = 0; k < 7; k++) begin
      n_chk++;
      if (k >= cap_data.size() || cap_src[k] !== es[k] || cap_data[k] !== ed[k] || cap_cyc[k] != cap_cyc[0] + k) begin
        n_fail++;
        $display("FAIL early_beat%0d: got s%b %h cyc%0d want s%b %h cyc%0d", k,
                 (k < cap_src.size()) ? cap_src[k] : 1'bx,
                 (k < cap_data.size()) ? cap_data[k] : 8'hxx,
                 (k < cap_cyc.size()) ? cap_cyc[k] : -1, es[k], ed[k],
                 (cap_cyc.size() > 0) ? cap_cyc[0] + k : -1);
      end
    end
  endtask

  task automatic test_cfg_en();
    logic [7:0] ed [8];
    logic       es [8];
    ed = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h80, 8'h81, 8'h82, 8'h83};
    es = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 20; i++) begin
      d0.push_back(8'(i));
      d1.push_back(8'(8'h80 + i));
    end
    repeat (3) step();
    cfg_en = 1'b0;
    for (int s = 0; s < 3; s++) begin
      step();
      n_chk++; if (bus.o_sig_valid !== 1'b0) begin n_fail++; $display("FAIL cfg_gated%0d: got valid %b want 0", s, bus.o_sig_valid); end
    end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL cfg_busy: got %b want 1", busy); end
    cfg_en = 1'b1;
    repeat (10) step();
    for (int k = 0; k < 8; k++) begin
      n_chk++;
      if (k >= cap_data.size() || cap_src[k] !== es[k] || cap_data[k] !== ed[k]) begin
        n_fail++;
        $display("FAIL cfg_beat%0d: got s%b %h want s%b %h", k,
                 (k < cap_src.size()) ? cap_src[k] : 1'bx,
                 (k < cap_data.size()) ? cap_data[k] : 8'hxx, es[k], ed[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      d0.push_back(8'(i));
      d1.push_back(8'(8'h80 + i));
    end
    repeat (7) step();
    #2;
    i_rst = 1'b1;
    #1;
    n_chk++; if (bus.o_sig_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b want 0", bus.o_sig_valid); end
    n_chk++; if (bus.o_sig_data !== 8'h00) begin n_fail++; $display("FAIL arst_data: got %h want 00", bus.o_sig_data); end
    n_chk++; if (bus.o_sig_src !== 1'b0) begin n_fail++; $display("FAIL arst_src: got %b want 0", bus.o_sig_src); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b want 0", busy); end
    n_chk++; if ({bus.o_sig_ready0, bus.o_sig_ready1} !== 2'b00) begin n_fail++; $display("FAIL arst_ready: got %b want 00", {bus.o_sig_ready0, bus.o_sig_ready1}); end
    clear_all();
    drive_inputs();
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    #1;
    d0 = '{8'h40, 8'h41};
    d1 = '{8'hC0, 8'hC1};
    repeat (6) step();
    n_chk++;
    if (cap_src.size() == 0 || cap_src[0] !== 1'b0 || cap_data[0] !== 8'h40) begin
      n_fail++;
      $display("FAIL arst_first_grant: got s%b %h want s0 40",
               (cap_src.size() > 0) ? cap_src[0] : 1'bx,
               (cap_data.size() > 0) ? cap_data[0] : 8'hxx);
    end
  endtask

  initial begin
    i_rst = 1'b1;
    cfg_en = 1'b1;
    bus.i_sig_ready = 1'b1;
    bus.i_sig_valid0 = 1'b0;
    bus.i_sig_data0 = 8'h00;
    bus.i_sig_valid1 = 1'b0;
    bus.i_sig_data1 = 8'h00;
    test_reset();
    test_single();
    test_tie_burst();
    test_backpressure();
    test_early_switch();
    test_cfg_en();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sub_rr_arb.md
# sub_rr_arb

Two-requester round-robin arbiter that shares one downstream `sub2` datapath between the `inst0_sub1` and `inst1_sub1` producers. Each producer stream enters a private 2-entry FIFO. A grant FSM with a burst limit selects which FIFO drains into a single registered output stage, and that stage drives the shared `sub2` input. Each output beat is tagged with its source index so the downstream logic can de-multiplex results.

## Interface
Parameters:
- `DW`, 8, data width of every stream.
- `MAX_BURST`, 4, maximum consecutive beats granted to one requester while the other is waiting. Legal range 1..15.

Ports:
- `i_clk`  in  1  single clock; all logic is rising-edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_sig_valid0`  in  1  requester 0 beat valid.
- `i_sig_data0`  in  DW  requester 0 beat data.
- `o_sig_ready0`  out  1  requester 0 may transfer this cycle.
- `i_sig_valid1`, `i_sig_data1`, `o_sig_ready1`: same as above, for requester 1.
- `o_sig_valid`  out  1  output beat valid.
- `o_sig_data`  out  DW  output beat data.
- `o_sig_src`  out  1  index of the requester that produced the current output beat.
- `i_sig_ready`  in  1  downstream accepts the output beat.
- `i_cfg_en`  in  1  arbitration enable. When low, no new beat is loaded into the output stage.
- `o_busy`  out  1  high if either FIFO or the output stage holds data.

## Operation
- **Input side (per requester x):** a transfer occurs when `i_sig_validx & o_sig_readyx`.
  - `o_sig_readyx = !fifox_full`, where full means 2 entries.
  - The FIFO preserves order. A simultaneous write and read on a full FIFO is not allowed, because ready is already low.
- **Output stage:** a single register holding `{valid, src, data}`.
  - `load = i_cfg_en & (!o_sig_valid | i_sig_ready) & (fifo0_nonempty | fifo1_nonempty)`.
  - On `load`, the stage takes the head of the selected FIFO, and that FIFO pops in the same cycle.
  - If `!load & i_sig_ready`, `o_sig_valid` clears.
  - If `o_sig_valid & !i_sig_ready`, data, src and valid hold stable.
- **Grant FSM states:** IDLE, G0, G1, plus a `burst_cnt` (4 bits) and a `last` register (last granted index).
  - **IDLE:** on `load`, grant the only nonempty FIFO. If both are nonempty, grant `!last`. Go to Gx with `burst_cnt=1`.
  - **Gx, on `load`, keep x:** if fifox is nonempty and (`burst_cnt < MAX_BURST` or the other FIFO is empty), load from x. `burst_cnt` increments, saturating at 15.
  - **Gx, on `load`, switch:** otherwise, if the other FIFO y is nonempty, load from y. Go to Gy with `burst_cnt=1` and `last=x`.
  - **Gx, both FIFOs empty:** on a cycle where both are empty and no `load` occurs, go to IDLE with `last=x`.
  - **No `load` for another reason:** if `i_cfg_en` is low or the output is stalled, state and `burst_cnt` hold.
- **Fairness bound:** a waiting requester is served within at most `MAX_BURST` output loads.
- **`i_cfg_en` low:** the inputs still fill their FIFOs and the output stage still drains. Re-enabling resumes from the held state.

## Timing
- **Reset values:** FSM=IDLE, `last=1` (so requester 0 wins the first tie), `burst_cnt=0`, both FIFOs empty.
  - Outputs: `o_sig_valid=0`, `o_sig_data=0`, `o_sig_src=0`, `o_busy=0`, `o_sig_ready0=o_sig_ready1=1` after reset.
  - The ready outputs are 0 while `i_rst` is asserted.
- **Latency:** a beat accepted at edge N is visible on `o_sig_valid` after edge N+1 at the earliest (2-cycle pass-through). There is no combinational path from input to output.
- **Throughput:** 1 beat/cycle sustained with `i_sig_ready=1`.
- **Timing of readiness:** `o_sig_readyx` depends only on FIFO occupancy, so it is registered-state driven. `i_sig_ready` only affects `load`, so it has no combinational path to `o_sig_readyx`.
- **Simultaneous events:**
  - A write and a pop on the same FIFO in one cycle are both honoured, and occupancy is unchanged.
  - A switch decision and an output stall in the same cycle give no switch, because no `load` occurs.
- **Reset mid-operation:** asynchronous clear of all state. In-flight FIFO and output contents are discarded, and no partial beat is emitted.

## Test plan
- **Single requester:** reset, then requester 0 sends 0x11, 0x22, 0x33 back-to-back with `i_sig_ready=1`. Required response: output 0x11, 0x22, 0x33 with `src=0` on consecutive cycles, the first appearing 2 cycles after the first accept, and `o_busy` falls after the last beat.
- **Tie and burst limit:** both requesters stream continuously (r0: 0x00.., r1: 0x80..) with `MAX_BURST=4`. Required response: the first grant goes to r0, and the `src` pattern is 0,0,0,0,1,1,1,1,0…, with per-source order preserved.
- **Output backpressure:** hold `i_sig_ready=0` for 6 cycles while both requesters send. Required response:
  - `o_sig_valid`, data and src are stable through the stall.
  - Each FIFO fills to 2, after which `o_sig_readyx` drops.
  - On release, the beats drain with no loss or duplication.
- **Early switch when the burst owner empties:** r0 sends 2 beats and r1 sends 5 beats. Required response: `src` is 0,0,1,1,1,1,1, with no idle cycle at the switch and no limit applied to r1 while r0 is empty.
- **`i_cfg_en` gating:** drop `i_cfg_en` mid-stream for 3 cycles. Required response:
  - The output drains its current beat and then `o_sig_valid` stays 0.
  - The FSM state and `burst_cnt` hold.
  - After re-enable, arbitration resumes with the same owner.
- **Asynchronous reset mid-burst:** assert `i_rst` between clock edges mid-burst. Required response: all outputs reach their reset values immediately, and the first grant after reset goes to r0.
